// File: rtl/id_branch_hazard_unit_if.sv
// ID branch hazard unit bundle.
// Master drives pipeline hazard info, slave returns selects.
interface id_branch_hazard_unit_if #(
  parameter int CNT_W = 16
);
  logic             Branch_ID;
  logic             Branch_Ne_ID;
  logic [4:0]       Rs_ID;
  logic [4:0]       Rt_ID;
  logic             RegWrite_EX;
  logic [4:0]       Rd_EX;
  logic             RegWrite_MEM;
  logic [4:0]       Rd_MEM;
  logic             RegWrite_WB;
  logic [4:0]       Rd_WB;
  logic             Comparetor_ID;
  logic             Forward_C_ID;
  logic             Forward_D_ID;
  logic             Stall_ID;
  logic             Branch_Taken_ID;
  logic             Flush_IF_ID;
  logic [CNT_W-1:0] Stall_Cnt;
  logic [CNT_W-1:0] Taken_Cnt;

  modport master (
    output Branch_ID, Branch_Ne_ID,
    output Rs_ID, Rt_ID,
    output RegWrite_EX, Rd_EX,
    output RegWrite_MEM, Rd_MEM,
    output RegWrite_WB, Rd_WB,
    output Comparetor_ID,
    input  Forward_C_ID, Forward_D_ID,
    input  Stall_ID, Branch_Taken_ID,
    input  Flush_IF_ID,
    input  Stall_Cnt, Taken_Cnt
  );

  modport slave (
    input  Branch_ID, Branch_Ne_ID,
    input  Rs_ID, Rt_ID,
    input  RegWrite_EX, Rd_EX,
    input  RegWrite_MEM, Rd_MEM,
    input  RegWrite_WB, Rd_WB,
    input  Comparetor_ID,
    output Forward_C_ID, Forward_D_ID,
    output Stall_ID, Branch_Taken_ID,
    output Flush_IF_ID,
    output Stall_Cnt, Taken_Cnt
  );
endinterface

// File: rtl/id_branch_hazard_unit.sv
// ID-stage branch stall, WB forward select and resolve.
// Saturating stall/taken performance counters.
module id_branch_hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  id_branch_hazard_unit_if.slave bus
);
  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [CNT_W-1:0] CMAX = '1;

  state_t           r_state;
  state_t           w_next;
  logic             r_cnt;
  logic             w_cnt_next;
  logic             w_stall;
  logic             w_stall_o;
  logic             w_taken;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_taken_cnt;

  logic w_ex_rs, w_ex_rt;
  logic w_mem_rs, w_mem_rt;
  logic w_wb_rs, w_wb_rt;
  logic w_hz_ex, w_hz_mem;

  function automatic logic f_m(
    input logic       we,
    input logic [4:0] rd,
    input logic [4:0] r
  );
    return we && (rd == r) && (r != 5'd0);
  endfunction

  assign w_ex_rs  = f_m(bus.RegWrite_EX, bus.Rd_EX, bus.Rs_ID);
  assign w_ex_rt  = f_m(bus.RegWrite_EX, bus.Rd_EX, bus.Rt_ID);
  assign w_mem_rs = f_m(bus.RegWrite_MEM, bus.Rd_MEM, bus.Rs_ID);
  assign w_mem_rt = f_m(bus.RegWrite_MEM, bus.Rd_MEM, bus.Rt_ID);
  assign w_wb_rs  = f_m(bus.RegWrite_WB, bus.Rd_WB, bus.Rs_ID);
  assign w_wb_rt  = f_m(bus.RegWrite_WB, bus.Rd_WB, bus.Rt_ID);

  assign w_hz_ex  = bus.Branch_ID & (w_ex_rs | w_ex_rt);
  assign w_hz_mem = bus.Branch_ID & (w_mem_rs | w_mem_rt);

  // State and depth counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next state and stall; EX match outranks MEM.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_stall    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_hz_ex) begin
          w_stall    = 1'b1;
          w_cnt_next = 1'b1;
          w_next     = WAIT;
        end else if (w_hz_mem) begin
          w_stall = 1'b1;
        end
      end
      WAIT: begin
        w_stall    = 1'b1;
        w_cnt_next = 1'b0;
        w_next     = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign w_stall_o = rst_n & w_stall;
  assign w_taken   = rst_n & bus.Branch_ID & ~w_stall &
                     (bus.Comparetor_ID ^ bus.Branch_Ne_ID);

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_taken_cnt <= '0;
    end else begin
      if (w_stall_o && r_stall_cnt != CMAX)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_taken && r_taken_cnt != CMAX)
        r_taken_cnt <= r_taken_cnt + 1'b1;
    end
  end

  assign bus.Forward_C_ID    = rst_n & w_wb_rs;
  assign bus.Forward_D_ID    = rst_n & w_wb_rt;
  assign bus.Stall_ID        = w_stall_o;
  assign bus.Branch_Taken_ID = w_taken;
  assign bus.Flush_IF_ID     = w_taken;
  assign bus.Stall_Cnt       = r_stall_cnt;
  assign bus.Taken_Cnt       = r_taken_cnt;
endmodule

// File: tb/tb_id_branch_hazard_unit.sv
// Bench for id_branch_hazard_unit.
// Directed plus random steps against a stall-budget model.
module tb_id_branch_hazard_unit;
  localparam int CNT_W = 16;
  localparam int CMAX  = 65535;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  int   m_left;
  int   m_scnt;
  int   m_tcnt;

  id_branch_hazard_unit_if #(.CNT_W(CNT_W)) bus();

  id_branch_hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic bit hit(
    input logic       we,
    input logic [4:0] rd,
    input logic [4:0] r
  );
    return we && rd == r && r != 0;
  endfunction

  task automatic drive(
    input bit br, input bit ne,
    input int rs, input int rt,
    input bit wex, input int dex,
    input bit wmem, input int dmem,
    input bit wwb, input int dwb,
    input bit cmp
  );
    bus.Branch_ID     = br;
    bus.Branch_Ne_ID  = ne;
    bus.Rs_ID         = 5'(rs);
    bus.Rt_ID         = 5'(rt);
    bus.RegWrite_EX   = wex;
    bus.Rd_EX         = 5'(dex);
    bus.RegWrite_MEM  = wmem;
    bus.Rd_MEM        = 5'(dmem);
    bus.RegWrite_WB   = wwb;
    bus.Rd_WB         = 5'(dwb);
    bus.Comparetor_ID = cmp;
  endtask

  // One cycle: inputs already driven after a negedge.
  task automatic step(input bit do_chk);
    bit ex, mem, fc, fd, st, tk;
    #1;
    ex = bus.Branch_ID &&
         (hit(bus.RegWrite_EX, bus.Rd_EX, bus.Rs_ID) ||
          hit(bus.RegWrite_EX, bus.Rd_EX, bus.Rt_ID));
    mem = bus.Branch_ID &&
         (hit(bus.RegWrite_MEM, bus.Rd_MEM, bus.Rs_ID) ||
          hit(bus.RegWrite_MEM, bus.Rd_MEM, bus.Rt_ID));
    fc = hit(bus.RegWrite_WB, bus.Rd_WB, bus.Rs_ID);
    fd = hit(bus.RegWrite_WB, bus.Rd_WB, bus.Rt_ID);
    if (m_left > 0) st = 1;
    else st = ex || mem;
    tk = bus.Branch_ID && !st &&
         (bus.Comparetor_ID != bus.Branch_Ne_ID);
    if (do_chk) begin
      chk("stall", 32'(bus.Stall_ID), 32'(st));
      chk("taken", 32'(bus.Branch_Taken_ID), 32'(tk));
      chk("flush", 32'(bus.Flush_IF_ID), 32'(tk));
      chk("fwd_c", 32'(bus.Forward_C_ID), 32'(fc));
      chk("fwd_d", 32'(bus.Forward_D_ID), 32'(fd));
    end
    if (m_left > 0) m_left--;
    else if (ex) m_left = 1;
    if (st && m_scnt < CMAX) m_scnt++;
    if (tk && m_tcnt < CMAX) m_tcnt++;
    @(posedge clk);
    #1;
    if (do_chk) begin
      chk("stall_cnt", 32'(bus.Stall_Cnt), 32'(m_scnt));
      chk("taken_cnt", 32'(bus.Taken_Cnt), 32'(m_tcnt));
    end
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_left   = 0;
    m_scnt   = 0;
    m_tcnt   = 0;
    rst_n    = 1'b0;
    drive(1, 0, 3, 4, 0, 0, 0, 0, 1, 3, 1);
    #1;
    chk("rst_fwd_c", 32'(bus.Forward_C_ID), 0);
    chk("rst_taken", 32'(bus.Branch_Taken_ID), 0);
    chk("rst_scnt", 32'(bus.Stall_Cnt), 0);
    chk("rst_tcnt", 32'(bus.Taken_Cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // BEQ, no hazards, equal -> taken.
    drive(1, 0, 3, 4, 0, 0, 0, 0, 0, 0, 1);
    step(1);
    chk("t1_tcnt", 32'(bus.Taken_Cnt), 1);

    // BNE r5 through EX, MEM, WB.
    drive(1, 1, 5, 0, 1, 5, 0, 0, 0, 0, 1);
    step(1);
    drive(1, 1, 5, 0, 0, 0, 1, 5, 0, 0, 1);
    step(1);
    drive(1, 1, 5, 0, 0, 0, 0, 0, 1, 5, 1);
    #1;
    chk("t2_fwd_c", 32'(bus.Forward_C_ID), 1);
    chk("t2_stall", 32'(bus.Stall_ID), 0);
    chk("t2_taken", 32'(bus.Branch_Taken_ID), 0);
    step(1);
    chk("t2_scnt", 32'(bus.Stall_Cnt), 2);

    // BEQ r7 from MEM: one stall then forward.
    drive(1, 0, 1, 7, 0, 0, 1, 7, 0, 0, 1);
    step(1);
    drive(1, 0, 1, 7, 0, 0, 0, 0, 1, 7, 1);
    #1;
    chk("t3_fwd_d", 32'(bus.Forward_D_ID), 1);
    chk("t3_taken", 32'(bus.Branch_Taken_ID), 1);
    step(1);

    // r0 never matches.
    drive(1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0);
    #1;
    chk("t4_stall", 32'(bus.Stall_ID), 0);
    chk("t4_fwd_c", 32'(bus.Forward_C_ID), 0);
    step(1);

    // EX on Rs with WB on Rt.
    drive(1, 0, 2, 6, 1, 2, 0, 0, 1, 6, 0);
    step(1);
    drive(1, 0, 2, 6, 1, 9, 1, 2, 1, 6, 0);
    step(1);

    // Random traffic on a small register set.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3),
            $urandom_range(0, 1) == 1);
      step(1);
    end

    // Reset while in WAIT.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1);
    drive(1, 0, 8, 0, 1, 8, 0, 0, 1, 8, 1);
    step(1);
    chk("t5_wait", 32'(bus.Stall_ID), 1);
    rst_n = 1'b0;
    m_left = 0;
    m_scnt = 0;
    m_tcnt = 0;
    #1;
    chk("t5_stall", 32'(bus.Stall_ID), 0);
    chk("t5_fwd_c", 32'(bus.Forward_C_ID), 0);
    chk("t5_scnt", 32'(bus.Stall_Cnt), 0);
    chk("t5_tcnt", 32'(bus.Taken_Cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 8, 0, 1, 8, 1, 8, 0, 0, 1);
    step(1);

    // Saturate the stall counter with a held MEM hazard.
    drive(1, 0, 9, 0, 0, 0, 1, 9, 0, 0, 0);
    for (int i = 0; i < CMAX + 4; i++)
      step(i >= CMAX - 2);
    chk("t6_sat", 32'(bus.Stall_Cnt), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/id_branch_hazard_unit.md
Name: id_branch_hazard_unit

Overview:
- ID-stage branch hazard and forwarding control for the 5-stage MIPS32 pipeline.
- Drives the WB-forward selects Forward_C_ID/Forward_D_ID into the ID read-data compare mux, which forwards from WB only.
- Stalls a branch in ID until every source operand has reached WB or the register file.
- Consumes the mux's equality result (Comparetor_ID) to produce branch-taken and the IF/ID flush.
- Keeps saturating performance counters for stall cycles and taken branches.

Parameters:
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Branch_ID  in  1  ID instruction is a conditional branch.
- Branch_Ne_ID  in  1  1 = BNE, 0 = BEQ; valid when Branch_ID=1.
- Rs_ID  in  5  branch source register 1.
- Rt_ID  in  5  branch source register 2.
- RegWrite_EX  in  1  EX instruction writes the register file.
- Rd_EX  in  5  EX destination register.
- RegWrite_MEM  in  1  MEM instruction writes the register file.
- Rd_MEM  in  5  MEM destination register.
- RegWrite_WB  in  1  WB instruction writes the register file.
- Rd_WB  in  5  WB destination register.
- Comparetor_ID  in  1  equality of forwarded operands, from the compare mux.
- Forward_C_ID  out  1  select WB data for operand 1.
- Forward_D_ID  out  1  select WB data for operand 2.
- Stall_ID  out  1  hold PC and IF/ID; zero ID/EX control (bubble).
- Branch_Taken_ID  out  1  branch resolved taken this cycle; PC takes the branch target.
- Flush_IF_ID  out  1  clear IF/ID on the next edge.
- Stall_Cnt  out  CNT_W  saturating count of branch stall cycles.
- Taken_Cnt  out  CNT_W  saturating count of taken branches.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, Cnt=0, Stall_Cnt=0, Taken_Cnt=0. All combinational outputs are 0 while in reset.
- Match definitions (register 0 never matches):
  - mEX(r) = RegWrite_EX & Rd_EX==r & r!=0.
  - mMEM(r) likewise using the MEM signals.
  - mWB(r) likewise using the WB signals.
- Forwarding (combinational, independent of Branch_ID and state):
  - Forward_C_ID = mWB(Rs_ID); Forward_D_ID = mWB(Rt_ID).
- Required stall depth N, evaluated in IDLE only:
  - N = 2 if Branch_ID & (mEX(Rs_ID) | mEX(Rt_ID)).
  - else N = 1 if Branch_ID & (mMEM(Rs_ID) | mMEM(Rt_ID)).
  - else N = 0.
  - An EX match dominates a MEM match.
- FSM, states IDLE and WAIT; Cnt is 1 bit:
  - IDLE, N=0: no stall. Branch resolves this cycle.
  - IDLE, N=1: Stall_ID=1 for this cycle; next state IDLE. The producer is in WB next cycle, and re-evaluation gives N=0 with forwarding active.
  - IDLE, N=2: Stall_ID=1; Cnt<=1; next state WAIT.
  - WAIT: Stall_ID=1 unconditionally. Hazard inputs are ignored, because the bubble in EX makes them invalid. Cnt<=0; next state IDLE.
  - Total stall cycles equal N. The branch resolves in cycle T+N, where T is the first ID cycle.
- Resolution (combinational): Branch_Taken_ID = Branch_ID & ~Stall_ID & (Comparetor_ID ^ Branch_Ne_ID). Flush_IF_ID = Branch_Taken_ID.
- Stall_ID is never asserted with Branch_ID=0 while in IDLE. Non-branch load-use hazards are handled elsewhere.
- Counters, updated on the clock edge:
  - Stall_Cnt += 1 on every cycle with Stall_ID=1.
  - Taken_Cnt += 1 on every cycle with Branch_Taken_ID=1.
  - Both saturate at all-ones and never wrap.
- Reset mid-WAIT: returns to IDLE immediately. The first cycle after release re-evaluates from the inputs.
- Simultaneous EX and WB matches on different operands: stall as for N=2. Forward selects still track WB each cycle.

Test Plan:
- Branch BEQ, Rs=3, Rt=4; no matches; Comparetor_ID=1 -> Stall_ID=0, Branch_Taken_ID=1, Flush_IF_ID=1, Taken_Cnt 0->1.
- BNE, Rs=5; RegWrite_EX=1, Rd_EX=5; next cycle present Rd_MEM=5; then Rd_WB=5 -> Stall_ID=1 for 2 cycles. Third cycle: Forward_C_ID=1, Stall_ID=0; with Comparetor_ID=1, Branch_Taken_ID=0. Stall_Cnt=2.
- BEQ, Rt=7; RegWrite_MEM=1, Rd_MEM=7 -> 1 stall cycle. Next cycle Rd_WB=7 gives Forward_D_ID=1 and the branch resolves.
- Rs=0 with RegWrite_EX=1, Rd_EX=0 -> no stall, Forward_C_ID=0.
- Assert rst_n=0 during WAIT -> outputs 0 and counters 0 at once. After release with Branch_ID=0: Stall_ID=0.
- Force Stall_Cnt to all-ones (or run 65535 stall cycles), stall again -> Stall_Cnt stays 16'hFFFF.
